// File: rtl/bitrf_wr_seq.sv
// rtl/bitrf_wr_seq.sv - write/lookup/invalidate sequencer for the per-set way-bit regfile
//
// Purpose: serializes single-bit way updates into the bitrf through a one-entry
// stage, services set lookups with a one-cycle registered result, and runs an
// invalidate-all walk that clears every way bit one write per cycle.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   upd_valid/upd_ready        update handshake; upd_idx, upd_way_sel (one-hot), upd_bit
//   upd_err                    pulse: accepted update had a bad way select and was dropped
//   lk_valid/lk_ready          lookup handshake; lk_idx
//   lk_bits, lk_bits_valid     registered lookup result and its qualifying pulse
//   inv_req                    level request to start the invalidate walk (sampled in IDLE)
//   inv_busy, inv_done         walk in progress / completion pulse
//   rf_ra, rf_wa, rf_wr, rf_d, rf_way_sel, rf_q   regfile port (rf_q is combinational regs[rf_ra])

module bitrf_wr_seq #(
    parameter int SETS  = 8192,
    parameter int IDX_W = 13,
    parameter int WAYS  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [WAYS-1:0]  upd_way_sel,
    input  logic             upd_bit,
    output logic             upd_err,
    input  logic             lk_valid,
    output logic             lk_ready,
    input  logic [IDX_W-1:0] lk_idx,
    output logic [WAYS-1:0]  lk_bits,
    output logic             lk_bits_valid,
    input  logic             inv_req,
    output logic             inv_busy,
    output logic             inv_done,
    output logic [IDX_W-1:0] rf_ra,
    output logic [IDX_W-1:0] rf_wa,
    output logic             rf_wr,
    output logic             rf_d,
    output logic [WAYS-1:0]  rf_way_sel,
    input  logic [WAYS-1:0]  rf_q
);

    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             stg_vld;
    logic [IDX_W-1:0] stg_idx;
    logic [WAYS-1:0]  stg_way;
    logic             stg_bit;

    logic [IDX_W-1:0] walk_idx;
    logic [WAY_W-1:0] walk_way;

    logic is_idle;
    logic walk_start;
    logic walk_last;
    logic upd_acc;
    logic lk_acc;
    logic way_onehot;

    assign is_idle    = (state == IDLE);
    // A pending staged write must drain before the walk may start.
    assign walk_start = is_idle & inv_req & ~stg_vld;
    assign walk_last  = (walk_idx == IDX_W'(SETS - 1)) && (walk_way == WAY_W'(WAYS - 1));

    assign upd_ready = is_idle & ~walk_start;
    // The staged write owns rf_ra, and the walk entry cycle blocks lookups too.
    assign lk_ready  = is_idle & ~stg_vld & ~inv_req;

    assign upd_acc = upd_valid & upd_ready;
    assign lk_acc  = lk_valid & lk_ready;

    assign way_onehot = (upd_way_sel != '0) &&
                        ((upd_way_sel & (upd_way_sel - {{(WAYS-1){1'b0}}, 1'b1})) == '0);

    assign inv_busy = (state == WALK);
    // Read and write share one address so each write lands on the set being read.
    assign rf_wa = rf_ra;

    always_comb begin
        state_nxt  = state;
        rf_ra      = lk_idx;
        rf_wr      = 1'b0;
        rf_d       = 1'b0;
        rf_way_sel = '0;
        case (state)
            IDLE: begin
                if (walk_start) begin
                    state_nxt = WALK;
                end
                if (stg_vld) begin
                    rf_ra      = stg_idx;
                    rf_wr      = 1'b1;
                    rf_d       = stg_bit;
                    rf_way_sel = stg_way;
                end
            end
            WALK: begin
                rf_ra      = walk_idx;
                rf_wr      = 1'b1;
                rf_d       = 1'b0;
                rf_way_sel = WAYS'(1) << walk_way;
                if (walk_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            stg_vld       <= 1'b0;
            stg_idx       <= '0;
            stg_way       <= '0;
            stg_bit       <= 1'b0;
            walk_idx      <= '0;
            walk_way      <= '0;
            lk_bits       <= '0;
            lk_bits_valid <= 1'b0;
            upd_err       <= 1'b0;
            inv_done      <= 1'b0;
        end else begin
            state <= state_nxt;

            // The stage always drains the cycle after it loads, so it only
            // stays full under back-to-back accepts.
            stg_vld <= upd_acc & way_onehot;
            if (upd_acc) begin
                stg_idx <= upd_idx;
                stg_way <= upd_way_sel;
                stg_bit <= upd_bit;
            end
            upd_err <= upd_acc & ~way_onehot;

            lk_bits_valid <= lk_acc;
            if (lk_acc) begin
                lk_bits <= rf_q;
            end

            if (state == WALK) begin
                if (walk_way == WAY_W'(WAYS - 1)) begin
                    walk_way <= '0;
                    walk_idx <= walk_idx + IDX_W'(1);
                end else begin
                    walk_way <= walk_way + WAY_W'(1);
                end
            end else begin
                walk_idx <= '0;
                walk_way <= '0;
            end

            inv_done <= (state == WALK) & walk_last;
        end
    end

endmodule

// File: tb/tb_bitrf_wr_seq.sv
// tb/tb_bitrf_wr_seq.sv - scoreboard bench for bitrf_wr_seq with a behavioural regfile
module tb_bitrf_wr_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        upd_valid;
    logic        upd_ready;
    logic [12:0] upd_idx;
    logic [3:0]  upd_way_sel;
    logic        upd_bit;
    logic        upd_err;
    logic        lk_valid;
    logic        lk_ready;
    logic [12:0] lk_idx;
    logic [3:0]  lk_bits;
    logic        lk_bits_valid;
    logic        inv_req;
    logic        inv_busy;
    logic        inv_done;
    logic [12:0] rf_ra;
    logic [12:0] rf_wa;
    logic        rf_wr;
    logic        rf_d;
    logic [3:0]  rf_way_sel;
    logic [3:0]  rf_q;

    logic [3:0] mem [0:8191];
    logic [3:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int n_err  = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    bitrf_wr_seq #(.SETS(8192), .IDX_W(13), .WAYS(4)) dut (
        .clk(clk), .reset(reset),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx),
        .upd_way_sel(upd_way_sel), .upd_bit(upd_bit), .upd_err(upd_err),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_idx(lk_idx),
        .lk_bits(lk_bits), .lk_bits_valid(lk_bits_valid),
        .inv_req(inv_req), .inv_busy(inv_busy), .inv_done(inv_done),
        .rf_ra(rf_ra), .rf_wa(rf_wa), .rf_wr(rf_wr), .rf_d(rf_d),
        .rf_way_sel(rf_way_sel), .rf_q(rf_q)
    );

    assign rf_q = mem[rf_ra];

    always @(posedge clk) begin
        if (rf_wr) begin
            for (int w = 0; w < 4; w++) begin
                if (rf_way_sel[w]) mem[rf_wa][w] <= rf_d;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected lookup result whenever the DUT presents one.
    always @(negedge clk) begin
        if (!reset) begin
            if (lk_bits_valid) begin
                if (exp_q.size() == 0) begin
                    chk("lk_unexpected", 32'(lk_bits_valid), 32'd0);
                end else begin
                    chk("lk_bits", 32'(lk_bits), 32'(exp_q.pop_front()));
                end
            end
            if (upd_err) n_err++;
            if (inv_done) n_done++;
        end
    end

    task automatic upd(input logic [12:0] idx, input logic [3:0] ws, input logic b, input logic bad);
        int n = 0;
        @(posedge clk); #1;
        upd_valid = 1'b1; upd_idx = idx; upd_way_sel = ws; upd_bit = b;
        @(negedge clk);
        while (!upd_ready && n < 20) begin @(negedge clk); n++; end
        chk("upd_accept", 32'(upd_ready), 32'd1);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        @(negedge clk);
        if (bad) begin
            chk("upd_err_pulse", 32'(upd_err), 32'd1);
            chk("bad_no_wr", 32'(rf_wr), 32'd0);
        end else begin
            chk("upd_wr", 32'(rf_wr), 32'd1);
            chk("upd_wa", 32'(rf_wa), 32'(idx));
            chk("upd_ra", 32'(rf_ra), 32'(idx));
            chk("upd_ws", 32'(rf_way_sel), 32'(ws));
            chk("upd_d", 32'(rf_d), 32'(b));
        end
    endtask

    task automatic lookup(input logic [12:0] idx, input logic [3:0] exp);
        int n = 0;
        @(posedge clk); #1;
        lk_valid = 1'b1; lk_idx = idx;
        @(negedge clk);
        while (!lk_ready && n < 20) begin @(negedge clk); n++; end
        chk("lk_accept", 32'(lk_ready), 32'd1);
        chk("lk_ra", 32'(rf_ra), 32'(idx));
        exp_q.push_back(exp);
        @(posedge clk); #1;
        lk_valid = 1'b0;
        @(negedge clk);
        chk("lk_latency", 32'(lk_bits_valid), 32'd1);
    endtask

    // Starts at the negedge of the walk entry cycle.
    task automatic walk_full();
        int  busy = 0;
        int  cyc  = 0;
        bit  seen = 0;
        while (!seen && cyc < 40000) begin
            @(posedge clk); #1;
            inv_req = 1'b0;
            @(negedge clk);
            cyc++;
            if (inv_busy) busy++;
            if (cyc == 1) begin
                chk("walk0_wr", 32'(rf_wr), 32'd1);
                chk("walk0_wa", 32'(rf_wa), 32'd0);
                chk("walk0_ws", 32'(rf_way_sel), 32'h1);
                chk("walk0_d", 32'(rf_d), 32'd0);
                chk("walk0_updrdy", 32'(upd_ready), 32'd0);
            end
            if (cyc == 2) chk("walk1_ws", 32'(rf_way_sel), 32'h2);
            if (inv_done) begin
                seen = 1;
                chk("done_busy_low", 32'(inv_busy), 32'd0);
            end
        end
        chk("walk_busy_cycles", 32'(busy), 32'd32768);
        chk("walk_done_cycle", 32'(cyc), 32'd32769);
    endtask

    task automatic walk_enter();
        @(posedge clk); #1;
        inv_req = 1'b1;
        @(negedge clk);
        chk("entry_updrdy", 32'(upd_ready), 32'd0);
        chk("entry_lkrdy", 32'(lk_ready), 32'd0);
        chk("entry_busy", 32'(inv_busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 4'h0;
        reset = 1'b1; upd_valid = 1'b0; upd_idx = '0; upd_way_sel = '0; upd_bit = 1'b0;
        lk_valid = 1'b0; lk_idx = '0; inv_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_updrdy", 32'(upd_ready), 32'd1);
        chk("rst_lkrdy", 32'(lk_ready), 32'd1);
        chk("rst_busy", 32'(inv_busy), 32'd0);
        chk("rst_done", 32'(inv_done), 32'd0);
        chk("rst_wr", 32'(rf_wr), 32'd0);
        chk("rst_lkbits", 32'(lk_bits), 32'd0);
        chk("rst_lkvld", 32'(lk_bits_valid), 32'd0);
        chk("rst_err", 32'(upd_err), 32'd0);

        // Single update then lookup.
        upd(13'h005, 4'b0100, 1'b1, 1'b0);
        lookup(13'h005, 4'b0100);

        // Back-to-back updates to one set, same way twice.
        @(posedge clk); #1;
        upd_valid = 1'b1; upd_idx = 13'h1FFF; upd_way_sel = 4'b0001; upd_bit = 1'b1;
        @(negedge clk);
        chk("b2b_rdy", 32'(upd_ready), 32'd1);
        @(posedge clk); #1;
        upd_way_sel = 4'b1000;
        @(negedge clk);
        chk("b2b1_lkrdy", 32'(lk_ready), 32'd0);
        chk("b2b1_wr", 32'(rf_wr), 32'd1);
        chk("b2b1_ws", 32'(rf_way_sel), 32'h1);
        chk("b2b1_d", 32'(rf_d), 32'd1);
        chk("b2b1_updrdy", 32'(upd_ready), 32'd1);
        @(posedge clk); #1;
        upd_way_sel = 4'b0001; upd_bit = 1'b0;
        @(negedge clk);
        chk("b2b2_lkrdy", 32'(lk_ready), 32'd0);
        chk("b2b2_ws", 32'(rf_way_sel), 32'h8);
        chk("b2b2_d", 32'(rf_d), 32'd1);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        @(negedge clk);
        chk("b2b3_lkrdy", 32'(lk_ready), 32'd0);
        chk("b2b3_ws", 32'(rf_way_sel), 32'h1);
        chk("b2b3_d", 32'(rf_d), 32'd0);
        lookup(13'h1FFF, 4'b1000);

        // Non-one-hot way select is dropped.
        upd(13'h005, 4'b0110, 1'b1, 1'b1);
        lookup(13'h005, 4'b0100);

        // Full invalidate walk.
        upd(13'h000, 4'b0001, 1'b1, 1'b0);
        upd(13'h1000, 4'b1000, 1'b1, 1'b0);
        walk_enter();
        walk_full();
        lookup(13'h000, 4'b0000);
        lookup(13'h1000, 4'b0000);
        lookup(13'h1FFF, 4'b0000);
        lookup(13'h005, 4'b0000);

        // Reset in the middle of a walk.
        upd(13'h100, 4'b0100, 1'b1, 1'b0);
        walk_enter();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            inv_req = 1'b0;
            @(negedge clk);
        end
        chk("mid_busy", 32'(inv_busy), 32'd1);
        chk("mid_wr", 32'(rf_wr), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(inv_busy), 32'd0);
        chk("abort_updrdy", 32'(upd_ready), 32'd1);
        chk("abort_lkrdy", 32'(lk_ready), 32'd1);
        repeat (5) @(negedge clk);
        lookup(13'h100, 4'b0100);

        // Walk request while an update is staged.
        @(posedge clk); #1;
        upd_valid = 1'b1; upd_idx = 13'h0AA; upd_way_sel = 4'b0010; upd_bit = 1'b1;
        @(negedge clk);
        chk("stg_accept", 32'(upd_ready), 32'd1);
        @(posedge clk); #1;
        upd_valid = 1'b0; inv_req = 1'b1;
        @(negedge clk);
        chk("stg_wr", 32'(rf_wr), 32'd1);
        chk("stg_wa", 32'(rf_wa), 32'h0AA);
        chk("stg_ws", 32'(rf_way_sel), 32'h2);
        chk("stg_busy", 32'(inv_busy), 32'd0);
        chk("stg_lkrdy", 32'(lk_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stg_entry_updrdy", 32'(upd_ready), 32'd0);
        chk("stg_entry_lkrdy", 32'(lk_ready), 32'd0);
        chk("stg_entry_wr", 32'(rf_wr), 32'd0);
        walk_full();
        lookup(13'h0AA, 4'b0000);

        repeat (3) @(negedge clk);
        chk("lk_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("upd_err_count", 32'(n_err), 32'd1);
        chk("inv_done_count", 32'(n_done), 32'd2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
